// File: rtl/sonar_pkg.sv
// Shared types and default timing constants for the sonar echo ranger.
package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    DONE,
    FILT,
    FAIL,
    HOLD
  } state_e;

  localparam int CLK_PER_US_DEF = 100;
  localparam int TRIG_US_DEF    = 10;
  localparam int CYCLE_US_DEF   = 60000;
  localparam int TIMEOUT_US_DEF = 38000;
  localparam int US_PER_CM_DEF  = 58;
  localparam int DIST_W_DEF     = 20;

endpackage

// File: rtl/sonar_median3.sv
// Median-of-three filter over the last three accepted results.
// Until the window holds three entries the newest value passes through unchanged.
module sonar_median3
  import sonar_pkg::*;
#(
  parameter int W = DIST_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [W-1:0] win_q [3];
  logic [W-1:0] win_d [3];
  logic [1:0]   fill_q, fill_d;
  logic         out_valid_q;
  logic [W-1:0] lo, hi, hi_c, med;

  always_comb begin
    win_d[0] = in_valid ? in_data : win_q[0];
  end

  genvar gi;
  generate
    for (gi = 1; gi < 3; gi++) begin : g_shift
      always_comb begin
        win_d[gi] = in_valid ? win_q[gi-1] : win_q[gi];
      end
    end
    for (gi = 0; gi < 3; gi++) begin : g_win
      always_ff @(posedge clk) begin
        if (rst) win_q[gi] <= '0;
        else     win_q[gi] <= win_d[gi];
      end
    end
  endgenerate

  always_comb begin
    fill_d = fill_q;
    if (in_valid && fill_q != 2'd3) fill_d = fill_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      fill_q      <= fill_d;
      out_valid_q <= in_valid;
    end
  end

  // med = max(min(a,b), min(max(a,b), c))
  always_comb begin
    lo   = (win_q[0] < win_q[1]) ? win_q[0] : win_q[1];
    hi   = (win_q[0] < win_q[1]) ? win_q[1] : win_q[0];
    hi_c = (hi < win_q[2]) ? hi : win_q[2];
    med  = (lo > hi_c) ? lo : hi_c;
  end

  assign out_valid = out_valid_q;
  assign out_data  = (fill_q == 2'd3) ? med : win_q[0];

endmodule

// File: rtl/sonar_echo_ranger.sv
// HC-SR04-style ranger: periodic trigger, echo width timing, conversion to whole cm.
// Define SONAR_MEDIAN_EN to median-filter the last three good results.
module sonar_echo_ranger
  import sonar_pkg::*;
#(
  parameter int CLK_PER_US = CLK_PER_US_DEF,
  parameter int TRIG_US    = TRIG_US_DEF,
  parameter int CYCLE_US   = CYCLE_US_DEF,
  parameter int TIMEOUT_US = TIMEOUT_US_DEF,
  parameter int US_PER_CM  = US_PER_CM_DEF,
  parameter int DIST_W     = DIST_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              echo,
  output logic              trigger,
  output logic [DIST_W-1:0] distance,
  output logic              dist_valid,
  output logic              timeout
);

  localparam int PW = $clog2(CLK_PER_US + 1);
  // Wide enough for a full trigger + rise wait + max echo even if that overruns the period.
  localparam int CW = $clog2(CYCLE_US + TRIG_US + 2 * TIMEOUT_US + 2);
  localparam int TW = $clog2(TIMEOUT_US + 1);
  localparam int UW = $clog2(US_PER_CM + 1);

  state_e            state_q, state_d;
  logic              echo_meta_q, echo_sync_q, echo_prev_q;
  logic [PW-1:0]     pre_q, pre_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [TW-1:0]     wait_q, wait_d;
  logic [UW-1:0]     us_cnt_q, us_cnt_d;
  logic [DIST_W-1:0] cm_cnt_q, cm_cnt_d;
  logic [DIST_W-1:0] distance_q, distance_d;
  logic              trigger_q, trigger_d;
  logic              dist_valid_q, dist_valid_d;
  logic              timeout_q, timeout_d;
  logic              us_tick, echo_rise, echo_fall, wait_expired;

  assign us_tick      = (pre_q == PW'(CLK_PER_US - 1));
  assign echo_rise    = echo_sync_q & ~echo_prev_q;
  assign echo_fall    = ~echo_sync_q & echo_prev_q;
  assign wait_expired = us_tick && (wait_q == TW'(TIMEOUT_US - 1));
  assign pre_d        = us_tick ? '0 : pre_q + 1'b1;

`ifdef SONAR_MEDIAN_EN
  logic              med_in_valid;
  logic              med_valid;
  logic [DIST_W-1:0] med_out;

  sonar_median3 #(.W(DIST_W)) u_median (
    .clk      (clk),
    .rst      (rst),
    .in_valid (med_in_valid),
    .in_data  (cm_cnt_q),
    .out_valid(med_valid),
    .out_data (med_out)
  );
`endif

  always_comb begin
    state_d      = state_q;
    cyc_d        = us_tick ? cyc_q + 1'b1 : cyc_q;
    wait_d       = us_tick ? wait_q + 1'b1 : wait_q;
    us_cnt_d     = us_cnt_q;
    cm_cnt_d     = cm_cnt_q;
    distance_d   = distance_q;
    dist_valid_d = 1'b0;
    timeout_d    = timeout_q;
`ifdef SONAR_MEDIAN_EN
    med_in_valid = 1'b0;
`endif
    case (state_q)
      IDLE: if (us_tick) state_d = TRIG;
      TRIG: begin
        if (us_tick && cyc_q == CW'(TRIG_US - 1)) begin
          state_d = WAIT_RISE;
          wait_d  = '0;
        end
      end
      WAIT_RISE: begin
        if (echo_rise) begin
          state_d  = MEASURE;
          wait_d   = '0;
          us_cnt_d = '0;
          cm_cnt_d = '0;
        end else if (wait_expired) begin
          state_d = FAIL;
        end
      end
      MEASURE: begin
        if (us_tick) begin
          if (us_cnt_q == UW'(US_PER_CM - 1)) begin
            us_cnt_d = '0;
            if (cm_cnt_q != '1) cm_cnt_d = cm_cnt_q + 1'b1;
          end else begin
            us_cnt_d = us_cnt_q + 1'b1;
          end
        end
        if (echo_fall)         state_d = DONE;
        else if (wait_expired) state_d = FAIL;
      end
      DONE: begin
        timeout_d = 1'b0;
`ifdef SONAR_MEDIAN_EN
        med_in_valid = 1'b1;
        state_d      = FILT;
`else
        distance_d   = cm_cnt_q;
        dist_valid_d = 1'b1;
        state_d      = HOLD;
`endif
      end
`ifdef SONAR_MEDIAN_EN
      FILT: begin
        if (med_valid) distance_d = med_out;
        dist_valid_d = med_valid;
        state_d      = HOLD;
      end
`endif
      FAIL: begin
        timeout_d = 1'b1;
        state_d   = HOLD;
      end
      HOLD: if (us_tick && cyc_q >= CW'(CYCLE_US - 1)) state_d = TRIG;
      default: state_d = IDLE;
    endcase
    if (state_d == TRIG && state_q != TRIG) cyc_d = '0;
    trigger_d = (state_d == TRIG);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      echo_meta_q  <= 1'b0;
      echo_sync_q  <= 1'b0;
      echo_prev_q  <= 1'b0;
      pre_q        <= '0;
      cyc_q        <= '0;
      wait_q       <= '0;
      us_cnt_q     <= '0;
      cm_cnt_q     <= '0;
      distance_q   <= '0;
      trigger_q    <= 1'b0;
      dist_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      echo_meta_q  <= echo;
      echo_sync_q  <= echo_meta_q;
      echo_prev_q  <= echo_sync_q;
      pre_q        <= pre_d;
      cyc_q        <= cyc_d;
      wait_q       <= wait_d;
      us_cnt_q     <= us_cnt_d;
      cm_cnt_q     <= cm_cnt_d;
      distance_q   <= distance_d;
      trigger_q    <= trigger_d;
      dist_valid_q <= dist_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign trigger    = trigger_q;
  assign distance   = distance_q;
  assign dist_valid = dist_valid_q;
  assign timeout    = timeout_q;

endmodule
